// File: rtl/esp_sid_pkg.sv
// Shared defaults and constants for the SID phi2 clock generator and heartbeat block.
package esp_sid_pkg;

  localparam int unsigned CLK_HZ_DEF     = 32'd100_000_000;
  localparam int unsigned SID_HALF_DEF   = 32'd50;
  localparam int unsigned BLINK_HALF_DEF = 32'd50_000_000;
  localparam int unsigned ACC_W          = 32'd32;
  localparam logic [31:0] PAL_INC_DEF    = 32'd42_316_079;

  // Counter width for a 0..n-1 range; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/esp_sid_clkgen.sv
// SID phi2 clock generator: integer half-period divider by default, or a
// 32-bit phase accumulator when ESP_SID_PAL_EN is defined.
module esp_sid_clkgen
  import esp_sid_pkg::*;
#(
`ifdef ESP_SID_PAL_EN
  parameter logic [ACC_W-1:0] PAL_INC = PAL_INC_DEF
`else
  parameter int unsigned SID_HALF = SID_HALF_DEF
`endif
) (
  input  logic clk,
  input  logic rst,
  output logic sid_clk
);

`ifdef ESP_SID_PAL_EN

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;

  // Phase step, wraps modulo 2^ACC_W.
  always_comb begin
    acc_d = acc_q + PAL_INC;
  end

  // Accumulator register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q <= {ACC_W{1'b0}};
    end else begin
      acc_q <= acc_d;
    end
  end

  // MSB of the accumulator is itself a flop output.
  assign sid_clk = acc_q[ACC_W-1];

`else

  localparam int unsigned    CW       = cnt_width(SID_HALF);
  localparam logic [CW-1:0]  CNT_LAST = CW'(SID_HALF - 32'd1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(32'd1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          sid_clk_q;
  logic          sid_clk_d;

  // Half-period count; toggle the output on the same edge as the wrap.
  always_comb begin
    cnt_d     = cnt_q;
    sid_clk_d = sid_clk_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d     = {CW{1'b0}};
      sid_clk_d = ~sid_clk_q;
    end else begin
      cnt_d     = cnt_q + CNT_ONE;
      sid_clk_d = sid_clk_q;
    end
  end

  // Divider state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q     <= {CW{1'b0}};
      sid_clk_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      sid_clk_q <= sid_clk_d;
    end
  end

  assign sid_clk = sid_clk_q;

`endif

endmodule

// File: rtl/esp_sid_top.sv
// SID phi2 clock, 1 Hz heartbeat LED and reset-status LED.
// Define ESP_SID_PAL_EN to replace the integer divider with the PAL phase accumulator.
module esp_sid_top
  import esp_sid_pkg::*;
#(
  parameter int unsigned CLK_HZ     = CLK_HZ_DEF,
  parameter int unsigned SID_HALF   = SID_HALF_DEF,
  parameter int unsigned BLINK_HALF = BLINK_HALF_DEF,
  parameter logic [31:0] PAL_INC    = PAL_INC_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic led_d1,
  output logic led_d2,
  output logic sid_clk
);

  if ((SID_HALF < 32'd2) || (BLINK_HALF < 32'd1) || (CLK_HZ == 32'd0)) begin : g_bad_params
    $error("esp_sid_top: SID_HALF must be >= 2, BLINK_HALF >= 1, CLK_HZ > 0");
  end

  localparam int unsigned   BW      = cnt_width(BLINK_HALF);
  localparam logic [BW-1:0] HB_LAST = BW'(BLINK_HALF - 32'd1);
  localparam logic [BW-1:0] HB_ONE  = BW'(32'd1);

  logic [BW-1:0] hb_cnt_q;
  logic [BW-1:0] hb_cnt_d;
  logic          led_d1_q;
  logic          led_d1_d;
  logic          led_d2_q;
  logic          led_d2_d;

  esp_sid_clkgen #(
`ifdef ESP_SID_PAL_EN
    .PAL_INC (PAL_INC)
`else
    .SID_HALF(SID_HALF)
`endif
  ) u_clkgen (
    .clk    (clk),
    .rst    (rst),
    .sid_clk(sid_clk)
  );

  // Heartbeat divider and reset-status LED next state.
  always_comb begin
    hb_cnt_d = hb_cnt_q;
    led_d1_d = led_d1_q;
    led_d2_d = ~rst;
    if (hb_cnt_q == HB_LAST) begin
      hb_cnt_d = {BW{1'b0}};
      led_d1_d = ~led_d1_q;
    end else begin
      hb_cnt_d = hb_cnt_q + HB_ONE;
      led_d1_d = led_d1_q;
    end
  end

  // LED state registers; led_d2 records the previous cycle's reset sample.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hb_cnt_q <= {BW{1'b0}};
      led_d1_q <= 1'b0;
      led_d2_q <= 1'b1;
    end else begin
      hb_cnt_q <= hb_cnt_d;
      led_d1_q <= led_d1_d;
      led_d2_q <= led_d2_d;
    end
  end

  assign led_d1 = led_d1_q;
  assign led_d2 = led_d2_q;

endmodule

// File: tb/tb_esp_sid_top.sv
// Directed self-checking bench for esp_sid_top in integer divider mode.
module tb_esp_sid_top;

  localparam int SID_HALF   = 50;
  localparam int BLINK_HALF = 8;

  logic clk = 1'b0;
  logic rst;
  logic led_d1;
  logic led_d2;
  logic sid_clk;

  int n_checks = 0;
  int n_fail   = 0;

  esp_sid_top #(
    .SID_HALF  (SID_HALF),
    .BLINK_HALF(BLINK_HALF)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .led_d1 (led_d1),
    .led_d2 (led_d2),
    .sid_clk(sid_clk)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Release reset and run n edges, comparing outputs against closed-form
  // expectations: after edge k, sid_clk = (k/SID_HALF)%2, led_d1 = (k/BLINK_HALF)%2.
  task automatic run_active(input int n, output int sid_err, output int led_err,
                            output int d2_err, output int rises, output int first_rise,
                            output int first_fall, output int bad_period, output int led_tog);
    logic prev_sid;
    logic prev_led;
    int   last_rise;
    sid_err = 0; led_err = 0; d2_err = 0; rises = 0; first_rise = -1;
    first_fall = -1; bad_period = 0; led_tog = 0; last_rise = -1;
    prev_sid = 1'b0;
    prev_led = 1'b0;
    rst = 1'b1;
    for (int k = 1; k <= n; k++) begin
      step();
      if (sid_clk !== 1'(((k / SID_HALF) % 2))) sid_err++;
      if (led_d1 !== 1'(((k / BLINK_HALF) % 2))) led_err++;
      if (led_d2 !== 1'b0) d2_err++;
      if (prev_sid == 1'b0 && sid_clk == 1'b1) begin
        rises++;
        if (first_rise < 0) first_rise = k;
        if (last_rise >= 0 && (k - last_rise) != 2 * SID_HALF) bad_period++;
        last_rise = k;
      end
      if (prev_sid == 1'b1 && sid_clk == 1'b0 && first_fall < 0) first_fall = k;
      if (prev_led != led_d1) led_tog++;
      prev_sid = sid_clk;
      prev_led = led_d1;
    end
  endtask

  int sid_err, led_err, d2_err, rises, first_rise, first_fall, bad_period, led_tog;
  int hold_dev;

  initial begin
    rst = 1'b0;
    @(negedge clk);

    // Long reset hold: outputs must sit at 0/0/1 with no toggles.
    hold_dev = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (sid_clk !== 1'b0 || led_d1 !== 1'b0 || led_d2 !== 1'b1) hold_dev++;
    end
    check_val("hold_deviations", hold_dev, 0);
    check_val("hold_sid_clk", sid_clk, 0);
    check_val("hold_led_d1", led_d1, 0);
    check_val("hold_led_d2", led_d2, 1);

    // Short reset then 20 full sid_clk periods.
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check_val("pre_release_led_d2", led_d2, 1);
    run_active(2000, sid_err, led_err, d2_err, rises, first_rise, first_fall, bad_period, led_tog);
    check_val("run_sid_waveform", sid_err, 0);
    check_val("run_led_d1_waveform", led_err, 0);
    check_val("run_led_d2_low", d2_err, 0);
    check_val("run_first_rise", first_rise, 50);
    check_val("run_first_fall", first_fall, 100);
    check_val("run_rise_count", rises, 20);
    check_val("run_bad_periods", bad_period, 0);
    check_val("run_led_toggles", led_tog, 2000 / BLINK_HALF);

    // Reset at count 37 of the second half-period (sid_clk high).
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step();
    run_active(87, sid_err, led_err, d2_err, rises, first_rise, first_fall, bad_period, led_tog);
    check_val("mid1_waveform", sid_err + led_err + d2_err, 0);
    check_val("mid1_sid_before", sid_clk, 1);
    rst = 1'b0;
    step();
    check_val("mid1_sid_after", sid_clk, 0);
    check_val("mid1_led_d1_after", led_d1, 0);
    check_val("mid1_led_d2_after", led_d2, 1);

    // Reset at count 37 of the third half-period (led_d1 high).
    run_active(137, sid_err, led_err, d2_err, rises, first_rise, first_fall, bad_period, led_tog);
    check_val("mid2_waveform", sid_err + led_err + d2_err, 0);
    check_val("mid2_led_d1_before", led_d1, 1);
    rst = 1'b0;
    step();
    check_val("mid2_sid_after", sid_clk, 0);
    check_val("mid2_led_d1_after", led_d1, 0);
    check_val("mid2_led_d2_after", led_d2, 1);

    // Timing restarts from scratch after release.
    run_active(160, sid_err, led_err, d2_err, rises, first_rise, first_fall, bad_period, led_tog);
    check_val("restart_waveform", sid_err + led_err + d2_err, 0);
    check_val("restart_first_rise", first_rise, 50);
    check_val("restart_first_fall", first_fall, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/esp_sid_top.md
ESP_SID_TOP -- requirements
Module: esp_sid_top

Interface
REQ-001 Parameter CLK_HZ, default 100000000, system clock frequency in Hz (10 ns period).
REQ-002 Parameter SID_HALF, default 50, clk cycles per sid_clk half-period in integer mode (1 MHz at default).
REQ-003 Parameter BLINK_HALF, default 50000000, clk cycles per led_d1 half-period (1 Hz at default); overridable to small values for simulation.
REQ-004 Parameter PAL_INC, default 42316079, 32-bit phase increment for PAL mode (985248 Hz from 100 MHz).
REQ-005 Port clk  input  1  single system clock; all logic on rising edge.
REQ-006 Port rst  input  1  synchronous, active-low reset; one clock, reset is synchronous and active-low.
REQ-007 Port led_d1  output  1  heartbeat LED, active-high.
REQ-008 Port led_d2  output  1  reset-status LED, active-high.
REQ-009 Port sid_clk  output  1  SID phi2 clock, registered, no combinational path from any input.

Function
REQ-010 All outputs SHALL be driven directly from flip-flops.
REQ-011 Integer mode: half-period counter cnt (width ceil(log2(SID_HALF))) SHALL increment each cycle; when cnt == SID_HALF-1 it SHALL wrap to 0 and sid_clk SHALL toggle in the same cycle.
REQ-012 Integer mode: first sid_clk rising edge SHALL occur on the SID_HALF-th rising clk edge after rst samples 1; period SHALL be exactly 2*SID_HALF cycles, 50% duty.
REQ-013 Heartbeat counter SHALL count 0..BLINK_HALF-1 and toggle led_d1 on wrap, same rule as REQ-011; first toggle on the BLINK_HALF-th active cycle.
REQ-014 led_d2 SHALL be 1 in any cycle following a cycle in which rst sampled 0, and 0 in any cycle following a cycle in which rst sampled 1.
REQ-015 Counters SHALL never exceed their terminal value; wrap is unconditional, no stall input exists.
REQ-016 SID_HALF < 2 or BLINK_HALF < 1 SHALL be rejected at elaboration.

Reset
REQ-017 While rst samples 0: sid_clk=0, led_d1=0, led_d2=1, all counters and the phase accumulator=0.
REQ-018 Reset asserted mid-period SHALL clear state on the next edge regardless of counter value; release restarts timing from REQ-012/REQ-013.

Configuration
REQ-019 Macro ESP_SID_PAL_EN defined: sid_clk SHALL be bit 31 of a 32-bit accumulator acc <= acc + PAL_INC (modulo 2^32), reset to 0; SID_HALF unused; mean frequency 985248 Hz +/-1 Hz, edge jitter <= 1 clk cycle.
REQ-020 Macro ESP_SID_PAL_EN undefined: integer divider per REQ-011/012 only; no accumulator logic instantiated.
REQ-021 LED and reset behaviour SHALL be identical in both configurations.

Structure
REQ-022 Package esp_sid_pkg SHALL hold defaults for CLK_HZ, SID_HALF, BLINK_HALF, PAL_INC and the accumulator width constant (32).
REQ-023 Sub-module esp_sid_clkgen SHALL contain the sid_clk generator (both modes); heartbeat and led_d2 logic stay in the top.

Verification
REQ-024 rst held 0 for 1000 cycles -> sid_clk=0, led_d1=0, led_d2=1 throughout, no toggles.
REQ-025 Integer mode, rst 0 for 5 cycles then 1 -> led_d2 falls one edge after release; sid_clk rises at edge 50, falls at edge 100, period 100 cycles (1.000 us) over 20 periods.
REQ-026 BLINK_HALF=8 -> led_d1 toggles every 8 cycles after release, exactly 50% duty.
REQ-027 Reset re-asserted at cycle 37 of a sid_clk half-period -> next edge sid_clk=0, led_d1=0, led_d2=1; after release first sid_clk rise again at edge 50.
REQ-028 ESP_SID_PAL_EN defined, run 10 ms -> 9852 or 9853 sid_clk rising edges; high/low times 50 or 51 cycles each.
